// File: rtl/bsg_axil_skid_slice.sv
// bsg_axil_skid_slice
//   Registered AXI-Lite slice between the shell OCL port and the manycore link.
//   Every channel is a 2-entry skid buffer, so all valid/ready/payload paths are
//   cut while still moving one beat per cycle. Outstanding writes and reads are
//   counted, AW/AR are throttled at max_outstanding_p, and a B/R response with
//   nothing outstanding raises a sticky err_o.
// Ports
//   clk_i, resetn_i          clock, async active-low reset
//   s_aw*/s_w*/s_b*/s_ar*/s_r*  slave-side AXI-Lite channels (toward shell)
//   m_aw*/m_w*/m_b*/m_ar*/m_r*  master-side AXI-Lite channels (toward link)
//   wr_pending_o, rd_pending_o  outstanding write / read counts
//   err_o                       sticky response-underflow flag

// One channel: main reg drives the output, skid reg catches the beat that
// arrives while the consumer stalls.
module bsg_axil_skid_slice_ch
  #(parameter int unsigned width_p = 1)
   (input  logic               clk_i
   ,input  logic               resetn_i
   ,input  logic               in_valid_i
   ,input  logic [width_p-1:0] in_data_i
   ,output logic               in_ready_o
   ,output logic               out_valid_o
   ,output logic [width_p-1:0] out_data_o
   ,input  logic               out_ready_i
   );

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

   state_e             state_q, state_n;
   logic               ready_q;
   logic [width_p-1:0] main_q, skid_q;
   logic               push, pop;
   logic               load_main_in, load_main_skid, load_skid;

   assign push        = in_valid_i & ready_q;
   assign pop         = (state_q != EMPTY) & out_ready_i;
   assign in_ready_o  = ready_q;
   assign out_valid_o = (state_q != EMPTY);
   assign out_data_o  = main_q;

   // Next-state and payload-load decode
   always_comb begin
      state_n        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         EMPTY: if (push) begin
            state_n      = ONE;
            load_main_in = 1'b1;
         end
         ONE: begin
            if (push && !pop) begin
               state_n   = FULL;
               load_skid = 1'b1;
            end else if (!push && pop) begin
               state_n   = EMPTY;
            end else if (push && pop) begin
               load_main_in = 1'b1;
            end
         end
         FULL: if (pop) begin
            state_n        = ONE;
            load_main_skid = 1'b1;
         end
         default: state_n = EMPTY;
      endcase
   end

   // Ready is a flop held low through reset; it rises on the first edge after release
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= EMPTY;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_n;
         ready_q <= (state_n != FULL);
      end
   end

   // Payload registers are qualified by state, so they need no reset
   always_ff @(posedge clk_i) begin
      if (load_main_in)        main_q <= in_data_i;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data_i;
   end

endmodule

module bsg_axil_skid_slice
  #(parameter int unsigned addr_width_p      = 32
   ,parameter int unsigned data_width_p      = 32
   ,parameter int unsigned max_outstanding_p = 4
   ,localparam int unsigned strb_width_lp    = data_width_p/8
   ,localparam int unsigned cnt_width_lp     = $clog2(max_outstanding_p+1)
   )
   (input  logic                     clk_i
   ,input  logic                     resetn_i
   // slave side
   ,input  logic [addr_width_p-1:0]  s_awaddr_i
   ,input  logic                     s_awvalid_i
   ,output logic                     s_awready_o
   ,input  logic [data_width_p-1:0]  s_wdata_i
   ,input  logic [strb_width_lp-1:0] s_wstrb_i
   ,input  logic                     s_wvalid_i
   ,output logic                     s_wready_o
   ,output logic [1:0]               s_bresp_o
   ,output logic                     s_bvalid_o
   ,input  logic                     s_bready_i
   ,input  logic [addr_width_p-1:0]  s_araddr_i
   ,input  logic                     s_arvalid_i
   ,output logic                     s_arready_o
   ,output logic [data_width_p-1:0]  s_rdata_o
   ,output logic [1:0]               s_rresp_o
   ,output logic                     s_rvalid_o
   ,input  logic                     s_rready_i
   // master side
   ,output logic [addr_width_p-1:0]  m_awaddr_o
   ,output logic                     m_awvalid_o
   ,input  logic                     m_awready_i
   ,output logic [data_width_p-1:0]  m_wdata_o
   ,output logic [strb_width_lp-1:0] m_wstrb_o
   ,output logic                     m_wvalid_o
   ,input  logic                     m_wready_i
   ,input  logic [1:0]               m_bresp_i
   ,input  logic                     m_bvalid_i
   ,output logic                     m_bready_o
   ,output logic [addr_width_p-1:0]  m_araddr_o
   ,output logic                     m_arvalid_o
   ,input  logic                     m_arready_i
   ,input  logic [data_width_p-1:0]  m_rdata_i
   ,input  logic [1:0]               m_rresp_i
   ,input  logic                     m_rvalid_i
   ,output logic                     m_rready_o
   // status
   ,output logic [cnt_width_lp-1:0]  wr_pending_o
   ,output logic [cnt_width_lp-1:0]  rd_pending_o
   ,output logic                     err_o
   );

   logic                    aw_ready, ar_ready;
   logic                    wr_room, rd_room;
   logic                    wr_inc, wr_dec, rd_inc, rd_dec;
   logic [cnt_width_lp-1:0] wr_cnt_q, wr_cnt_n, rd_cnt_q, rd_cnt_n;
   logic                    err_q, err_n;

   // Throttle uses registered count only, so no input reaches a ready combinationally
   assign wr_room     = (wr_cnt_q < cnt_width_lp'(max_outstanding_p));
   assign rd_room     = (rd_cnt_q < cnt_width_lp'(max_outstanding_p));
   assign s_awready_o = aw_ready & wr_room;
   assign s_arready_o = ar_ready & rd_room;

   bsg_axil_skid_slice_ch #(.width_p(addr_width_p)) aw_slice
     (.clk_i, .resetn_i
     ,.in_valid_i (s_awvalid_i & wr_room)
     ,.in_data_i  (s_awaddr_i)
     ,.in_ready_o (aw_ready)
     ,.out_valid_o(m_awvalid_o)
     ,.out_data_o (m_awaddr_o)
     ,.out_ready_i(m_awready_i));

   bsg_axil_skid_slice_ch #(.width_p(data_width_p+strb_width_lp)) w_slice
     (.clk_i, .resetn_i
     ,.in_valid_i (s_wvalid_i)
     ,.in_data_i  ({s_wdata_i, s_wstrb_i})
     ,.in_ready_o (s_wready_o)
     ,.out_valid_o(m_wvalid_o)
     ,.out_data_o ({m_wdata_o, m_wstrb_o})
     ,.out_ready_i(m_wready_i));

   bsg_axil_skid_slice_ch #(.width_p(2)) b_slice
     (.clk_i, .resetn_i
     ,.in_valid_i (m_bvalid_i)
     ,.in_data_i  (m_bresp_i)
     ,.in_ready_o (m_bready_o)
     ,.out_valid_o(s_bvalid_o)
     ,.out_data_o (s_bresp_o)
     ,.out_ready_i(s_bready_i));

   bsg_axil_skid_slice_ch #(.width_p(addr_width_p)) ar_slice
     (.clk_i, .resetn_i
     ,.in_valid_i (s_arvalid_i & rd_room)
     ,.in_data_i  (s_araddr_i)
     ,.in_ready_o (ar_ready)
     ,.out_valid_o(m_arvalid_o)
     ,.out_data_o (m_araddr_o)
     ,.out_ready_i(m_arready_i));

   bsg_axil_skid_slice_ch #(.width_p(data_width_p+2)) r_slice
     (.clk_i, .resetn_i
     ,.in_valid_i (m_rvalid_i)
     ,.in_data_i  ({m_rdata_i, m_rresp_i})
     ,.in_ready_o (m_rready_o)
     ,.out_valid_o(s_rvalid_o)
     ,.out_data_o ({s_rdata_o, s_rresp_o})
     ,.out_ready_i(s_rready_i));

   assign wr_inc = s_awvalid_i & s_awready_o;
   assign wr_dec = s_bvalid_o  & s_bready_i;
   assign rd_inc = s_arvalid_i & s_arready_o;
   assign rd_dec = s_rvalid_o  & s_rready_i;

   // Outstanding counters; a response with a zero count flags err and never wraps
   always_comb begin
      wr_cnt_n = wr_cnt_q;
      rd_cnt_n = rd_cnt_q;
      err_n    = err_q;
      if (wr_dec && (wr_cnt_q == '0)) err_n = 1'b1;
      if (rd_dec && (rd_cnt_q == '0)) err_n = 1'b1;
      if (wr_inc && !wr_dec)                            wr_cnt_n = wr_cnt_q + cnt_width_lp'(1);
      else if (!wr_inc && wr_dec && (wr_cnt_q != '0))   wr_cnt_n = wr_cnt_q - cnt_width_lp'(1);
      if (rd_inc && !rd_dec)                            rd_cnt_n = rd_cnt_q + cnt_width_lp'(1);
      else if (!rd_inc && rd_dec && (rd_cnt_q != '0))   rd_cnt_n = rd_cnt_q - cnt_width_lp'(1);
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_cnt_q <= wr_cnt_n;
         rd_cnt_q <= rd_cnt_n;
         err_q    <= err_n;
      end
   end

   assign wr_pending_o = wr_cnt_q;
   assign rd_pending_o = rd_cnt_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_bsg_axil_skid_slice.sv
// Directed bench for bsg_axil_skid_slice: reset release, AR streaming,
// W backpressure, AW throttle, R underflow and mid-burst reset.
module tb_bsg_axil_skid_slice;

   logic        clk;
   logic        resetn;
   logic [31:0] s_awaddr;  logic s_awvalid; logic s_awready;
   logic [31:0] s_wdata;   logic [3:0] s_wstrb; logic s_wvalid; logic s_wready;
   logic [1:0]  s_bresp;   logic s_bvalid;  logic s_bready;
   logic [31:0] s_araddr;  logic s_arvalid; logic s_arready;
   logic [31:0] s_rdata;   logic [1:0] s_rresp; logic s_rvalid; logic s_rready;
   logic [31:0] m_awaddr;  logic m_awvalid; logic m_awready;
   logic [31:0] m_wdata;   logic [3:0] m_wstrb; logic m_wvalid; logic m_wready;
   logic [1:0]  m_bresp;   logic m_bvalid;  logic m_bready;
   logic [31:0] m_araddr;  logic m_arvalid; logic m_arready;
   logic [31:0] m_rdata;   logic [1:0] m_rresp; logic m_rvalid; logic m_rready;
   logic [2:0]  wr_pending, rd_pending;
   logic        err;

   int checks   = 0;
   int failures = 0;

   bsg_axil_skid_slice #(.addr_width_p(32), .data_width_p(32), .max_outstanding_p(4)) dut
     (.clk_i(clk), .resetn_i(resetn)
     ,.s_awaddr_i(s_awaddr), .s_awvalid_i(s_awvalid), .s_awready_o(s_awready)
     ,.s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready)
     ,.s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready)
     ,.s_araddr_i(s_araddr), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready)
     ,.s_rdata_o(s_rdata), .s_rresp_o(s_rresp), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready)
     ,.m_awaddr_o(m_awaddr), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready)
     ,.m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready)
     ,.m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready)
     ,.m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready)
     ,.m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready)
     ,.wr_pending_o(wr_pending), .rd_pending_o(rd_pending), .err_o(err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_readys(input string tag, input logic exp);
      check_eq({tag, "_awready"}, 64'(s_awready), 64'(exp));
      check_eq({tag, "_wready"},  64'(s_wready),  64'(exp));
      check_eq({tag, "_arready"}, 64'(s_arready), 64'(exp));
      check_eq({tag, "_bready"},  64'(m_bready),  64'(exp));
      check_eq({tag, "_rready"},  64'(m_rready),  64'(exp));
   endtask

   task automatic check_mvalids_low(input string tag);
      check_eq({tag, "_awvalid"}, 64'(m_awvalid), 64'd0);
      check_eq({tag, "_wvalid"},  64'(m_wvalid),  64'd0);
      check_eq({tag, "_arvalid"}, 64'(m_arvalid), 64'd0);
      check_eq({tag, "_bvalid"},  64'(s_bvalid),  64'd0);
      check_eq({tag, "_rvalid"},  64'(s_rvalid),  64'd0);
   endtask

   initial begin
      resetn   = 1'b0;
      s_awaddr = '0; s_awvalid = 1'b0;
      s_wdata  = '0; s_wstrb   = 4'hF; s_wvalid = 1'b0;
      s_bready = 1'b0;
      s_araddr = '0; s_arvalid = 1'b0;
      s_rready = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
      m_bresp = '0; m_bvalid = 1'b0;
      m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;

      // ---- reset release ----
      repeat (5) step();
      check_readys("rst_hold", 1'b0);
      check_mvalids_low("rst_hold");
      check_eq("rst_wr_pending", 64'(wr_pending), 64'd0);
      check_eq("rst_rd_pending", 64'(rd_pending), 64'd0);
      check_eq("rst_err", 64'(err), 64'd0);
      resetn = 1'b1;
      #1;
      check_readys("rel_cycle0", 1'b0);
      step();
      check_readys("rel_cycle1", 1'b1);
      check_mvalids_low("rel_cycle1");

      // ---- AR streaming with concurrent R responses ----
      m_arready = 1'b1;
      s_rready  = 1'b1;
      for (int i = 0; i < 17; i++) begin
         s_arvalid = (i < 16);
         s_araddr  = 32'(i * 4);
         m_rvalid  = (i >= 1);
         m_rdata   = 32'(32'h100 + i);
         if (i == 0) check_eq("ar_lat_pre", 64'(m_arvalid), 64'd0);
         if (i < 16) check_eq($sformatf("ar_rdy%0d", i), 64'(s_arready), 64'd1);
         step();
         if (i < 16) begin
            check_eq($sformatf("ar_valid%0d", i), 64'(m_arvalid), 64'd1);
            check_eq($sformatf("ar_addr%0d", i), 64'(m_araddr), 64'(i * 4));
         end
      end
      s_arvalid = 1'b0;
      m_rvalid  = 1'b0;
      check_eq("ar_drained", 64'(m_arvalid), 64'd0);
      check_eq("r_last_data", 64'(s_rdata), 64'h110);
      step();
      check_eq("ar_rd_pending0", 64'(rd_pending), 64'd0);
      check_eq("ar_err0", 64'(err), 64'd0);

      // ---- W backpressure ----
      m_wready = 1'b0;
      s_wvalid = 1'b1;
      s_wdata  = 32'hA0A0_0000;
      check_eq("w_rdy_a", 64'(s_wready), 64'd1);
      step();
      check_eq("w_rdy_b", 64'(s_wready), 64'd1);
      check_eq("w_valid_b", 64'(m_wvalid), 64'd1);
      s_wdata = 32'hA0A0_0001;
      step();
      check_eq("w_rdy_full", 64'(s_wready), 64'd0);
      check_eq("w_data_stall", 64'(m_wdata), 64'hA0A0_0000);
      s_wdata = 32'hA0A0_0002;
      step();
      check_eq("w_rdy_full2", 64'(s_wready), 64'd0);
      check_eq("w_data_stall2", 64'(m_wdata), 64'hA0A0_0000);
      m_wready = 1'b1;
      step();
      check_eq("w_data1", 64'(m_wdata), 64'hA0A0_0001);
      check_eq("w_rdy_back", 64'(s_wready), 64'd1);
      step();
      s_wvalid = 1'b0;
      check_eq("w_data2", 64'(m_wdata), 64'hA0A0_0002);
      check_eq("w_valid2", 64'(m_wvalid), 64'd1);
      step();
      check_eq("w_empty", 64'(m_wvalid), 64'd0);

      // ---- AW throttle ----
      m_awready = 1'b1;
      s_bready  = 1'b1;
      s_awvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_awaddr = 32'(32'h2000 + i * 4);
         check_eq($sformatf("aw_rdy%0d", i), 64'(s_awready), 64'd1);
         step();
         check_eq($sformatf("aw_pend%0d", i), 64'(wr_pending), 64'(i + 1));
      end
      check_eq("aw_throttled", 64'(s_awready), 64'd0);
      step();
      check_eq("aw_hold_pend", 64'(wr_pending), 64'd4);
      check_eq("aw_hold_rdy", 64'(s_awready), 64'd0);
      s_awvalid = 1'b0;
      m_bvalid  = 1'b1;
      m_bresp   = 2'b10;
      step();
      m_bvalid = 1'b0;
      check_eq("b_valid", 64'(s_bvalid), 64'd1);
      check_eq("b_resp", 64'(s_bresp), 64'd2);
      step();
      check_eq("b_pend3", 64'(wr_pending), 64'd3);
      check_eq("b_awrdy", 64'(s_awready), 64'd1);
      m_bvalid = 1'b1;
      m_bresp  = 2'b00;
      step();
      m_bvalid  = 1'b0;
      s_awvalid = 1'b1;
      s_awaddr  = 32'h2010;
      step();
      s_awvalid = 1'b0;
      check_eq("aw_b_same", 64'(wr_pending), 64'd3);
      m_bvalid = 1'b1;
      repeat (3) step();
      m_bvalid = 1'b0;
      step();
      check_eq("wr_drain", 64'(wr_pending), 64'd0);
      check_eq("wr_err0", 64'(err), 64'd0);

      // ---- R underflow ----
      s_rready = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'hDEAD_BEEF;
      step();
      m_rvalid = 1'b0;
      check_eq("uf_pre_err", 64'(err), 64'd0);
      step();
      check_eq("uf_err", 64'(err), 64'd1);
      check_eq("uf_pend", 64'(rd_pending), 64'd0);
      repeat (3) step();
      check_eq("uf_err_sticky", 64'(err), 64'd1);
      check_eq("uf_pend_sticky", 64'(rd_pending), 64'd0);

      // ---- mid-burst reset with W full ----
      m_wready = 1'b0;
      s_wvalid = 1'b1;
      s_wdata  = 32'hC0C0_0000;
      step();
      s_wdata = 32'hC0C0_0001;
      step();
      check_eq("mr_full", 64'(s_wready), 64'd0);
      check_eq("mr_valid", 64'(m_wvalid), 64'd1);
      resetn = 1'b0;
      #1;
      check_eq("mr_wvalid_async", 64'(m_wvalid), 64'd0);
      check_eq("mr_err", 64'(err), 64'd0);
      check_eq("mr_wr_pend", 64'(wr_pending), 64'd0);
      check_eq("mr_rd_pend", 64'(rd_pending), 64'd0);
      s_wvalid = 1'b0;
      m_wready = 1'b1;
      repeat (3) step();
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq($sformatf("mr_no_stale%0d", i), 64'(m_wvalid), 64'd0);
      end
      check_readys("mr_after", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
